// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared state encoding and default addresses for the RTC access sequencer
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD_A = 3'd1,
      ST_CMD_D = 3'd2,
      ST_REG_A = 3'd3,
      ST_REG_D = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   localparam int         SEL_W_DEF     = 4;
   localparam logic [3:0] ADDR_CMD_DEF  = 4'hD;
   localparam logic [3:0] ADDR_BASE_DEF = 4'h4;
   localparam logic [SEL_W_DEF-1:0] SEL_CMD = {SEL_W_DEF{1'b1}};

endpackage

// File: rtl/secuenciador_lectura_rtc.sv
// rtl/secuenciador_lectura_rtc.sv - walks a command access plus N_REG register accesses, each address-then-data
module secuenciador_lectura_rtc
   import rtc_pkg::*;
#(
   parameter int                N_REG     = 9,
   parameter int                ADDR_W    = 4,
   parameter int                SEL_W     = 4,
   parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_BASE_DEF,
   parameter logic [ADDR_W-1:0] ADDR_CMD  = ADDR_CMD_DEF,
   parameter bit                CMD_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              modo,
   input  logic              bus_done,
   output logic              ocupado,
   output logic              fin,
   output logic              op,
   output logic              i_en,
   output logic              ad,
   output logic              lw,
   output logic [ADDR_W-1:0] addr,
   output logic [SEL_W-1:0]  sel_reg
);

   localparam logic [SEL_W-1:0] L_SEL_CMD  = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] L_IDX_LAST = SEL_W'(N_REG - 1);

   if (N_REG < 1 || N_REG > (2 ** SEL_W) - 1) begin : g_bad_n_reg
      $error("N_REG must be in 1..2**SEL_W-1");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_idx;
   logic [SEL_W-1:0] w_idx_nxt;
   logic             r_modo;
   logic             w_modo_nxt;

   logic              r_ocupado, r_fin, r_op, r_i_en, r_ad, r_lw;
   logic [ADDR_W-1:0] r_addr;
   logic [SEL_W-1:0]  r_sel_reg;

   logic              w_ocupado, w_fin, w_op, w_i_en, w_ad, w_lw;
   logic [ADDR_W-1:0] w_addr;
   logic [SEL_W-1:0]  w_sel_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_modo  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_modo  <= w_modo_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_modo_nxt  = r_modo;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_modo_nxt  = modo;
               w_idx_nxt   = '0;
               w_state_nxt = CMD_EN ? ST_CMD_A : ST_REG_A;
            end
         end
         ST_CMD_A: if (bus_done) w_state_nxt = ST_CMD_D;
         ST_CMD_D: begin
            if (bus_done) begin
               w_idx_nxt   = '0;
               w_state_nxt = ST_REG_A;
            end
         end
         ST_REG_A: if (bus_done) w_state_nxt = ST_REG_D;
         ST_REG_D: begin
            if (bus_done) begin
               if (r_idx == L_IDX_LAST) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_idx_nxt   = r_idx + SEL_W'(1);
                  w_state_nxt = ST_REG_A;
               end
            end
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy lines up with the state register.
   always_comb begin
      w_ocupado = (w_state_nxt != ST_IDLE);
      w_fin     = 1'b0;
      w_op      = 1'b0;
      w_i_en    = 1'b0;
      w_ad      = 1'b0;
      w_lw      = 1'b0;
      w_addr    = '0;
      w_sel_reg = '0;
      case (w_state_nxt)
         ST_CMD_A, ST_CMD_D: begin
            w_op      = (w_state_nxt == ST_CMD_A);
            w_ad      = (w_state_nxt == ST_CMD_D);
            w_i_en    = 1'b1;
            w_lw      = w_modo_nxt;
            w_addr    = ADDR_CMD;
            w_sel_reg = L_SEL_CMD;
         end
         ST_REG_A, ST_REG_D: begin
            w_op      = (w_state_nxt == ST_REG_A);
            w_ad      = (w_state_nxt == ST_REG_D);
            w_i_en    = 1'b1;
            w_lw      = w_modo_nxt;
            w_addr    = ADDR_BASE + ADDR_W'(w_idx_nxt);
            w_sel_reg = w_idx_nxt;
         end
         ST_FIN:  w_fin = 1'b1;
         default: w_fin = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ocupado <= 1'b0;
         r_fin     <= 1'b0;
         r_op      <= 1'b0;
         r_i_en    <= 1'b0;
         r_ad      <= 1'b0;
         r_lw      <= 1'b0;
         r_addr    <= '0;
         r_sel_reg <= '0;
      end else begin
         r_ocupado <= w_ocupado;
         r_fin     <= w_fin;
         r_op      <= w_op;
         r_i_en    <= w_i_en;
         r_ad      <= w_ad;
         r_lw      <= w_lw;
         r_addr    <= w_addr;
         r_sel_reg <= w_sel_reg;
      end
   end

   assign ocupado = r_ocupado;
   assign fin     = r_fin;
   assign op      = r_op;
   assign i_en    = r_i_en;
   assign ad      = r_ad;
   assign lw      = r_lw;
   assign addr    = r_addr;
   assign sel_reg = r_sel_reg;

endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// tb/tb_secuenciador_lectura_rtc.sv - directed bench for the RTC access sequencer
module tb_secuenciador_lectura_rtc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic start0, modo0, bd0;
   logic start1, modo1, bd1;
   logic ocupado0, fin0, op0, ien0, ad0, lw0;
   logic ocupado1, fin1, op1, ien1, ad1, lw1;
   logic [3:0] addr0, sel0, addr1, sel1;

   int total = 0;
   int bad   = 0;

   secuenciador_lectura_rtc dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .modo(modo0), .bus_done(bd0),
      .ocupado(ocupado0), .fin(fin0), .op(op0), .i_en(ien0), .ad(ad0), .lw(lw0),
      .addr(addr0), .sel_reg(sel0)
   );

   secuenciador_lectura_rtc #(.N_REG(3), .CMD_EN(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .modo(modo1), .bus_done(bd1),
      .ocupado(ocupado1), .fin(fin1), .op(op1), .i_en(ien1), .ad(ad1), .lw(lw1),
      .addr(addr1), .sel_reg(sel1)
   );

   // {ocupado, fin, op, i_en, ad, lw, addr, sel_reg}
   logic [13:0] act0, act1;
   assign act0 = {ocupado0, fin0, op0, ien0, ad0, lw0, addr0, sel0};
   assign act1 = {ocupado1, fin1, op1, ien1, ad1, lw1, addr1, sel1};

   // Expected outputs in cycle c after the accepting edge (c=1 is the first access phase).
   function automatic logic [13:0] exp_seq(int c, int n, int cmd, bit m);
      int na;
      int a;
      int ph;
      logic [3:0] ea;
      logic [3:0] es;
      na = 2 * (n + cmd);
      if (c >= 1 && c <= na) begin
         a  = (c - 1) / 2;
         ph = (c - 1) % 2;
         if (cmd == 1 && a == 0) begin
            ea = 4'hD;
            es = 4'hF;
         end else begin
            ea = 4'(4 + a - cmd);
            es = 4'(a - cmd);
         end
         return {1'b1, 1'b0, (ph == 0), 1'b1, (ph == 1), m, ea, es};
      end else if (c == na + 1) begin
         return {1'b1, 1'b1, 12'b0};
      end
      return 14'b0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start0 = 1'($urandom); modo0 = 1'($urandom); bd0 = 1'($urandom);
         start1 = 1'($urandom); modo1 = 1'($urandom); bd1 = 1'($urandom);
         #3;
         total++;
         if (act0 !== 14'b0 || act1 !== 14'b0) begin
            bad++;
            $display("FAIL reset_hold i=%0d got %h/%h want 0/0", i, act0, act1);
         end
         tick();
      end
      start0 = 0; modo0 = 0; bd0 = 0;
      start1 = 0; modo1 = 0; bd1 = 0;
      reset_n = 1'b1;
      tick();
      total++;
      if (act0 !== 14'b0 || act1 !== 14'b0) begin
         bad++;
         $display("FAIL reset_release got %h/%h want 0/0", act0, act1);
      end
   endtask

   task automatic test_full_read;
      int fins;
      fins = 0;
      modo0 = 1'b0; bd0 = 1'b1; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         if (fin0 === 1'b1) fins++;
         total++;
         if (act0 !== exp_seq(c, 9, 1, 1'b0)) begin
            bad++;
            $display("FAIL full_read c=%0d got %h want %h", c, act0, exp_seq(c, 9, 1, 1'b0));
         end
         tick();
      end
      total++;
      if (fins != 1) begin
         bad++;
         $display("FAIL full_read_fin_count got %0d want 1", fins);
      end
   endtask

   task automatic test_stall;
      bit found;
      modo0 = 1'b0; bd0 = 1'b1; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (8) tick();
      bd0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (act0 !== exp_seq(9, 9, 1, 1'b0)) begin
            bad++;
            $display("FAIL stall_hold i=%0d got %h want %h", i, act0, exp_seq(9, 9, 1, 1'b0));
         end
         tick();
      end
      bd0 = 1'b1;
      total++;
      if (act0 !== exp_seq(9, 9, 1, 1'b0)) begin
         bad++;
         $display("FAIL stall_last got %h want %h", act0, exp_seq(9, 9, 1, 1'b0));
      end
      tick();
      total++;
      if (act0 !== exp_seq(10, 9, 1, 1'b0)) begin
         bad++;
         $display("FAIL stall_advance got %h want %h", act0, exp_seq(10, 9, 1, 1'b0));
      end
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (fin0 === 1'b1) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL stall_fin_timeout got 0 want 1");
      end
      tick();
   endtask

   task automatic test_ignored_start;
      int fins;
      int fin_c;
      fins = 0; fin_c = -1;
      modo0 = 1'b0; bd0 = 1'b1; start0 = 1'b1;
      tick();
      for (int c = 1; c <= 30; c++) begin
         if (c == 22) begin
            start0 = 1'b0;
            total++;
            if (ocupado0 !== 1'b0) begin
               bad++;
               $display("FAIL ignored_start_idle got %b want 0", ocupado0);
            end
         end
         if (fin0 === 1'b1) begin
            fins++;
            fin_c = c;
         end
         tick();
      end
      total++;
      if (fins != 1 || fin_c != 21) begin
         bad++;
         $display("FAIL ignored_start_fin got count=%0d cyc=%0d want count=1 cyc=21", fins, fin_c);
      end
   endtask

   task automatic test_back_to_back;
      modo0 = 1'b0; bd0 = 1'b1; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (20) tick();
      total++;
      if (fin0 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_fin got %b want 1", fin0);
      end
      tick();
      total++;
      if (act0 !== 14'b0) begin
         bad++;
         $display("FAIL b2b_idle got %h want 0", act0);
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 21; c++) begin
         total++;
         if (act0 !== exp_seq(c, 9, 1, 1'b0)) begin
            bad++;
            $display("FAIL b2b_second c=%0d got %h want %h", c, act0, exp_seq(c, 9, 1, 1'b0));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      modo0 = 1'b0; bd0 = 1'b1; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (13) tick();
      total++;
      if (act0 !== exp_seq(14, 9, 1, 1'b0)) begin
         bad++;
         $display("FAIL mid_reg_d5 got %h want %h", act0, exp_seq(14, 9, 1, 1'b0));
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (act0 !== 14'b0) begin
         bad++;
         $display("FAIL mid_async_clear got %h want 0", act0);
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (act0 !== 14'b0) begin
            bad++;
            $display("FAIL mid_no_fin i=%0d got %h want 0", i, act0);
         end
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      total++;
      if (act0 !== exp_seq(1, 9, 1, 1'b0)) begin
         bad++;
         $display("FAIL mid_restart got %h want %h", act0, exp_seq(1, 9, 1, 1'b0));
      end
      repeat (21) tick();
   endtask

   task automatic test_write_nocmd;
      int fins;
      fins = 0;
      modo1 = 1'b1; bd1 = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      modo1 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (fin1 === 1'b1) fins++;
         total++;
         if (act1 !== exp_seq(c, 3, 0, 1'b1)) begin
            bad++;
            $display("FAIL write_nocmd c=%0d got %h want %h", c, act1, exp_seq(c, 3, 0, 1'b1));
         end
         tick();
      end
      total++;
      if (fins != 1) begin
         bad++;
         $display("FAIL write_nocmd_fin_count got %0d want 1", fins);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start0 = 0; modo0 = 0; bd0 = 0;
      start1 = 0; modo1 = 0; bd1 = 0;
      tick();
      test_reset();
      test_full_read();
      test_stall();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_write_nocmd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
